// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with internal combinational alu)
// Purpose  : Shares one combinational ALU between two requesters using
//            valid/ready handshakes and round-robin arbitration. The winning
//            request's operands are registered, evaluated for one cycle and
//            the result is held on a single response channel until accepted.
// Ports    : clk                 rising-edge clock
//            reset               synchronous, active-low reset
//            reqX_valid/ready    request handshake, X = 0 (sequencer), 1 (AGU)
//            reqX_a/b            request operands, N bits
//            reqX_op             request ALUControl code, 3 bits
//            rsp_valid/ready     response handshake
//            rsp_id              requester that issued the response
//            rsp_result/zero     registered ALUResult and Zero flag
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// alu : combinational ALU.
//   000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed set-less-than,
//   remaining codes produce zero.
// ----------------------------------------------------------------------------
module alu #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_op,
  output logic [N-1:0] o_result,
  output logic         o_zero
);

  always_comb begin
    o_result = '0;
    case (i_op)
      3'b000:  o_result = i_a + i_b;
      3'b001:  o_result = i_a - i_b;
      3'b010:  o_result = i_a & i_b;
      3'b011:  o_result = i_a | i_b;
      3'b100:  o_result = i_a ^ i_b;
      3'b101:  o_result = {{(N-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// ----------------------------------------------------------------------------
// alu_arbiter : top level
// ----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [2:0]   r_op;
  logic         r_id;
  logic         r_last_grant;
  logic         r_rsp_valid;
  logic         r_rsp_id;
  logic [N-1:0] r_rsp_result;
  logic         r_rsp_zero;

  logic         w_gnt0;
  logic         w_gnt1;
  logic         w_grant;
  logic [N-1:0] w_alu_result;
  logic         w_alu_zero;

  // Round-robin: a lone valid always wins; under contention the requester
  // that was not granted last time wins.
  assign w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);

  // Grants only happen in IDLE and never while reset is being applied, so a
  // requester cannot see a handshake that the FSM then discards.
  assign w_grant    = (r_state == S_IDLE) & reset;
  assign req0_ready = w_grant & w_gnt0;
  assign req1_ready = w_grant & w_gnt1;

  alu #(.N(N)) u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;  // requester 0 wins the first contention
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_a          <= w_gnt1 ? req1_a  : req0_a;
            r_b          <= w_gnt1 ? req1_b  : req0_b;
            r_op         <= w_gnt1 ? req1_op : req0_op;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_result <= w_alu_result;
          r_rsp_zero   <= w_alu_zero;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          // Response registers are left untouched on a stall.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Single-requester vectors are
//            table driven; contention, backpressure and reset-in-RESP are
//            hand-written sequences. Inputs are driven and outputs sampled on
//            the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic         rsp_valid, rsp_id, rsp_zero;
  logic         rsp_ready = 1'b1;
  logic [N-1:0] rsp_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One isolated operation with rsp_ready high; the FSM is in IDLE on entry
  // and on exit. Operands are corrupted right after the accept edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_op = v.op;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_op = v.op;
    end
    #1;
    chk("ready_granted", v.id ? req1_ready : req0_ready, 1);
    chk("ready_other",   v.id ? req0_ready : req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 100; req0_b = 100; req1_a = 100; req1_b = 100;
    #1;
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_ready",     {req0_ready, req1_ready}, 0);
    @(negedge clk);
    #1;
    chk("rsp_valid",  rsp_valid, 1);
    chk("rsp_result", rsp_result, v.exp_res);
    chk("rsp_zero",   rsp_zero, v.exp_zero);
    chk("rsp_id",     rsp_id, v.id);
    @(negedge clk);
    #1;
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin : main
    logic        ids  [4];
    logic [31:0] ress [4];
    int          cycs [4];
    int          nresp;
    logic [31:0] held_res;

    //            id    a             b             op      result        zero
    vecs[0] = '{1'b0, 32'd3,        32'd4,        3'b000, 32'd7,        1'b0};
    vecs[1] = '{1'b1, 32'd5,        32'd5,        3'b001, 32'd0,        1'b1};
    vecs[2] = '{1'b1, 32'd3,        32'd4,        3'b001, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{1'b0, 32'hF0,       32'h3C,       3'b010, 32'h30,       1'b0};
    vecs[4] = '{1'b1, 32'hF0,       32'h0F,       3'b011, 32'hFF,       1'b0};
    vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,        1'b1};
    vecs[6] = '{1'b1, 32'h80000000, 32'd1,        3'b001, 32'h7FFFFFFF, 1'b0};

    // Reset state
    reset_dut();
    #1;
    chk("reset_rsp_valid",  rsp_valid, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_zero",   rsp_zero, 0);
    chk("reset_rsp_id",     rsp_id, 0);
    chk("reset_ready",      {req0_ready, req1_ready}, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Contention: both valid continuously, rsp_ready high
    reset_dut();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 3'b010;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'b011;
    nresp = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid && nresp < 4) begin
        ids[nresp]  = rsp_id;
        ress[nresp] = rsp_result;
        cycs[nresp] = c;
        nresp++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("contention_count", nresp, 4);
    for (int i = 0; i < nresp; i++) begin
      chk("contention_id",     ids[i], i % 2);
      chk("contention_result", ress[i], (i % 2) ? 32'hFF : 32'h30);
      if (i > 0) chk("contention_spacing", cycs[i] - cycs[i-1], 3);
    end

    // Backpressure
    reset_dut();
    rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b000;
    #1;
    chk("bp_ready0", req0_ready, 1);
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd2; req1_op = 3'b001;
    #1;
    chk("bp_exec_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    #1;
    chk("bp_rsp_valid",  rsp_valid, 1);
    chk("bp_rsp_result", rsp_result, 30);
    chk("bp_rsp_id",     rsp_id, 0);
    held_res = rsp_result;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      req0_a = 32'd55;  // must not disturb the held response
      #1;
      chk("bp_hold_valid",  rsp_valid, 1);
      chk("bp_hold_result", rsp_result, held_res);
      chk("bp_hold_id",     rsp_id, 0);
      chk("bp_hold_zero",   rsp_zero, 0);
      chk("bp_hold_ready",  {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_next_ready1",   req1_ready, 1);
    chk("bp_next_ready0",   req0_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("bp_next_exec", rsp_valid, 0);
    @(negedge clk);
    #1;
    chk("bp_next_valid",  rsp_valid, 1);
    chk("bp_next_result", rsp_result, 5);
    chk("bp_next_id",     rsp_id, 1);

    // Reset while in RESP
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rr_rsp_valid",  rsp_valid, 1);
    chk("rr_rsp_result", rsp_result, 2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rr_after_valid",  rsp_valid, 0);
    chk("rr_after_result", rsp_result, 0);
    rsp_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      #1;
      chk("rr_no_response", rsp_valid, 0);
    end
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd1; req1_op = 3'b001;
    #1;
    chk("rr_grant0", req0_ready, 1);
    chk("rr_grant1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rr_final_result", rsp_result, 10);
    chk("rr_final_id",     rsp_id, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
